program_counter_unit: RTL and testbench
=======================================

// Module: program_counter_unit
// PURPOSE
//   Parametrised program-counter unit for the processor fetch stage: holds the PC, advances it by STEP,
//   and supports absolute load, call/return via an internal return-address stack, and halt/resume.
//   Wraps the combinational pc_incrementer and adds sequential control, stack and fault detection.
//   Drives instruction-memory address directly; o_pc_next feeds branch/link logic downstream.
// PARAMETERS
//   ADDR_W      11   PC / address width in bits
//   STEP        1    increment per advance; 1 <= STEP < 2**ADDR_W
//   RESET_ADDR  0    PC value after reset
//   STACK_DEPTH 4    return-address stack entries; power of two, >= 2
//   MAX_ADDR    2**ADDR_W-1  highest legal PC (used only with PC_BOUND_CHECK_EN)
// PORTS
//   i_clk        in   1       clock, rising edge
//   i_rst_n      in   1       asynchronous, active-low reset
//   i_enable     in   1       advance PC by STEP this cycle
//   i_load       in   1       jump: PC <= i_load_addr
//   i_call       in   1       push PC+STEP, PC <= i_load_addr
//   i_ret        in   1       PC <= popped return address
//   i_load_addr  in   ADDR_W  jump / call target
//   i_halt       in   1       enter HALT
//   i_resume     in   1       leave HALT
//   o_pc         out  ADDR_W  current PC (registered)
//   o_pc_next    out  ADDR_W  (o_pc + STEP) mod 2**ADDR_W, combinational
//   o_wrap       out  1       1-cycle pulse: last advance wrapped past 2**ADDR_W-1
//   o_halted     out  1       1 while in HALT
//   o_fault      out  1       1 while in FAULT (sticky)
//   o_stack_err  out  1       1-cycle pulse: call on full / ret on empty stack
//   o_depth      out  $clog2(STACK_DEPTH)+1  stack occupancy
// BEHAVIOUR
//   - Reset (async, any time incl. mid-call): o_pc=RESET_ADDR, state=RUN, depth=0, all flags 0.
//   - States: RUN, HALT, FAULT. RUN->HALT on i_halt; HALT->RUN on i_resume (i_halt wins if both);
//     RUN->FAULT on stack error (or bound error); FAULT exits only via reset.
//   - In HALT/FAULT: PC, stack frozen; all requests except i_halt/i_resume ignored.
//   - RUN priority per cycle: i_halt > i_load > i_ret > i_call > i_enable; lower ones dropped.
//     No request asserted: PC holds.
//   - All PC updates take effect at the next rising edge (1-cycle latency); o_pc_next tracks o_pc.
//   - Advance: PC <= PC+STEP, truncated to ADDR_W; o_wrap=1 next cycle iff carry out.
//   - Call: depth<STACK_DEPTH -> push o_pc_next, PC <= i_load_addr, depth+1.
//     depth==STACK_DEPTH -> no push, PC holds, o_stack_err pulse, ->FAULT.
//   - Ret: depth>0 -> PC <= top entry, depth-1. depth==0 -> PC holds, o_stack_err, ->FAULT.
//   - Stack is LIFO; contents not cleared by pop; only depth is architecturally visible.
// CONFIGURATION
//   PC_BOUND_CHECK_EN defined: any resulting PC > MAX_ADDR (advance, load, call target, ret)
//     is blocked: PC holds, extra output o_bound_err pulses 1 cycle, ->FAULT; advance never wraps.
//   Not defined: MAX_ADDR ignored, no o_bound_err port, addresses wrap modulo 2**ADDR_W.
// STRUCTURE
//   Package pc_pkg: state enum (PC_RUN=2'd0, PC_HALT=2'd1, PC_FAULT=2'd2), default
//     ADDR_W/STEP/STACK_DEPTH constants.
//   Sub-module pc_incrementer (ADDR_W, STEP): combinational sum + carry-out; instantiated once.
//   Stack: register array + depth counter inside program_counter_unit.
// TESTING
//   1 Reset, i_enable=1 for 5 cycles (STEP=1) -> o_pc 0,1,2,3,4,5; o_pc_next=o_pc+1.
//   2 i_load, addr=11'h7FE, then enable x2 -> 7FE,7FF,000; o_wrap=1 exactly on the 000 cycle.
//   3 call 11'h100 from pc=0x10, call 0x200, ret, ret -> 100,200,101,011; depth 1,2,1,0.
//   4 STACK_DEPTH=4: 5 calls -> 5th: o_stack_err pulse, o_pc holds, o_fault=1; ret ignored.
//   5 i_halt+i_load same cycle -> PC unchanged, o_halted=1; enable ignored; i_resume -> RUN.
//   6 i_rst_n low mid-call sequence (depth=3) -> immediately o_pc=RESET_ADDR, depth=0, flags 0.

Source files
------------

// File: rtl/pc_pkg.sv
// ============================================================================
//  Module   : pc_pkg
//  Purpose  : Shared definitions for the program-counter unit. Holds the
//             control state encoding and the default geometry constants.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    // Control state of the program-counter unit
    typedef enum logic [1:0] {
        PC_RUN   = 2'd0,
        PC_HALT  = 2'd1,
        PC_FAULT = 2'd2
    } pc_state_t;

    localparam int PC_ADDR_W      = 11;
    localparam int PC_STEP        = 1;
    localparam int PC_STACK_DEPTH = 4;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_incrementer.sv
// ============================================================================
//  Module   : pc_incrementer
//  Purpose  : Combinational PC + STEP with carry-out (sum truncated to ADDR_W).
//  Ports    : pc     in   ADDR_W  current PC
//             sum    out  ADDR_W  (pc + STEP) mod 2**ADDR_W
//             carry  out  1       1 when pc + STEP overflowed ADDR_W bits
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_incrementer #(
    parameter int ADDR_W = 11,
    parameter int STEP   = 1
) (
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sum,
    output logic              carry
);

    // One extra bit captures the carry out of the top address bit
    assign {carry, sum} = {1'b0, pc} + (ADDR_W+1)'(STEP);

endmodule : pc_incrementer

`default_nettype wire

// File: rtl/program_counter_unit.sv
// ============================================================================
//  Module   : program_counter_unit
//  Purpose  : Fetch-stage program counter. Holds the PC, advances it by STEP,
//             supports absolute load, call/return through an internal
//             return-address stack, halt/resume, and sticky fault detection.
//  Ports    : i_clk, i_rst_n (async, active low)
//             i_enable / i_load / i_call / i_ret / i_halt / i_resume requests
//             i_load_addr  jump / call target
//             o_pc         registered PC
//             o_pc_next    combinational PC + STEP
//             o_wrap       pulse: last advance carried out of ADDR_W bits
//             o_halted     1 while in HALT
//             o_fault      1 while in FAULT (left only through reset)
//             o_stack_err  pulse: call on full / ret on empty stack
//             o_depth      return-stack occupancy
//             o_bound_err  pulse: resulting PC above MAX_ADDR blocked
//                          (present only with PC_BOUND_CHECK_EN)
//  Config   : `define PC_BOUND_CHECK_EN to enable the MAX_ADDR bound check.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module program_counter_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = PC_ADDR_W,
    parameter int                STEP        = PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter int                STACK_DEPTH = PC_STACK_DEPTH
`ifdef PC_BOUND_CHECK_EN
    ,
    parameter logic [ADDR_W-1:0] MAX_ADDR    = {ADDR_W{1'b1}}
`endif
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_enable,
    input  logic                           i_load,
    input  logic                           i_call,
    input  logic                           i_ret,
    input  logic [ADDR_W-1:0]              i_load_addr,
    input  logic                           i_halt,
    input  logic                           i_resume,
    output logic [ADDR_W-1:0]              o_pc,
    output logic [ADDR_W-1:0]              o_pc_next,
    output logic                           o_wrap,
    output logic                           o_halted,
    output logic                           o_fault,
    output logic                           o_stack_err,
`ifdef PC_BOUND_CHECK_EN
    output logic                           o_bound_err,
`endif
    output logic [$clog2(STACK_DEPTH):0]   o_depth
);

    localparam int PW = $clog2(STACK_DEPTH);
    localparam int DW = PW + 1;

    pc_state_t         state, state_d;
    logic [ADDR_W-1:0] pc, pc_d;
    logic [DW-1:0]     depth, depth_d;
    logic              wrap, wrap_d;
    logic              stack_err, stack_err_d;
`ifdef PC_BOUND_CHECK_EN
    logic              bound_err, bound_err_d;
`endif

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic              push;
    logic [PW-1:0]     wr_idx;
    logic [PW-1:0]     top_idx;
    logic [ADDR_W-1:0] top;

    logic [ADDR_W-1:0] inc_sum;
    logic              inc_carry;

    pc_incrementer #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_inc (
        .pc    (pc),
        .sum   (inc_sum),
        .carry (inc_carry)
    );

    // While depth < STACK_DEPTH its low bits address the next free slot
    assign wr_idx  = depth[PW-1:0];
    assign top_idx = depth[PW-1:0] - PW'(1);
    assign top     = stack[top_idx];

    // Next-state decode; RUN priority: halt > load > ret > call > enable
    always_comb begin
        state_d     = state;
        pc_d        = pc;
        depth_d     = depth;
        wrap_d      = 1'b0;
        stack_err_d = 1'b0;
        push        = 1'b0;
`ifdef PC_BOUND_CHECK_EN
        bound_err_d = 1'b0;
`endif
        case (state)
            PC_RUN: begin
                if (i_halt) begin
                    state_d = PC_HALT;
                end else if (i_load) begin
`ifdef PC_BOUND_CHECK_EN
                    if (i_load_addr > MAX_ADDR) begin
                        bound_err_d = 1'b1;
                        state_d     = PC_FAULT;
                    end else
`endif
                    pc_d = i_load_addr;
                end else if (i_ret) begin
                    if (depth == '0) begin
                        stack_err_d = 1'b1;
                        state_d     = PC_FAULT;
                    end else
`ifdef PC_BOUND_CHECK_EN
                    if (top > MAX_ADDR) begin
                        bound_err_d = 1'b1;
                        state_d     = PC_FAULT;
                    end else
`endif
                    begin
                        pc_d    = top;
                        depth_d = depth - DW'(1);
                    end
                end else if (i_call) begin
                    if (depth == DW'(STACK_DEPTH)) begin
                        stack_err_d = 1'b1;
                        state_d     = PC_FAULT;
                    end else
`ifdef PC_BOUND_CHECK_EN
                    if (i_load_addr > MAX_ADDR) begin
                        bound_err_d = 1'b1;
                        state_d     = PC_FAULT;
                    end else
`endif
                    begin
                        push    = 1'b1;
                        pc_d    = i_load_addr;
                        depth_d = depth + DW'(1);
                    end
                end else if (i_enable) begin
`ifdef PC_BOUND_CHECK_EN
                    // A carry means the true sum exceeds every legal address
                    if (inc_carry || (inc_sum > MAX_ADDR)) begin
                        bound_err_d = 1'b1;
                        state_d     = PC_FAULT;
                    end else begin
                        pc_d = inc_sum;
                    end
`else
                    pc_d   = inc_sum;
                    wrap_d = inc_carry;
`endif
                end
            end
            PC_HALT: begin
                if (!i_halt && i_resume) begin
                    state_d = PC_RUN;
                end
            end
            default: begin
                state_d = PC_FAULT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= PC_RUN;
            pc        <= RESET_ADDR;
            depth     <= '0;
            wrap      <= 1'b0;
            stack_err <= 1'b0;
`ifdef PC_BOUND_CHECK_EN
            bound_err <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            depth     <= depth_d;
            wrap      <= wrap_d;
            stack_err <= stack_err_d;
`ifdef PC_BOUND_CHECK_EN
            bound_err <= bound_err_d;
`endif
        end
    end

    // Stack contents are not architecturally visible, so they need no reset
    always_ff @(posedge i_clk) begin
        if (push) begin
            stack[wr_idx] <= inc_sum;
        end
    end

    assign o_pc        = pc;
    assign o_pc_next   = inc_sum;
    assign o_wrap      = wrap;
    assign o_halted    = (state == PC_HALT);
    assign o_fault     = (state == PC_FAULT);
    assign o_stack_err = stack_err;
    assign o_depth     = depth;
`ifdef PC_BOUND_CHECK_EN
    assign o_bound_err = bound_err;
`endif

endmodule : program_counter_unit

`default_nettype wire

// File: tb/tb_program_counter_unit.sv
// ============================================================================
//  Module   : tb_program_counter_unit
//  Purpose  : Self-checking bench for program_counter_unit (default build,
//             ADDR_W=11, STEP=1, RESET_ADDR=0, STACK_DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_program_counter_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0;
    logic        halt = 1'b0, resume = 1'b0;
    logic [10:0] load_addr = '0;
    logic [10:0] pc, pc_next;
    logic        wrap, halted, fault, stack_err;
    logic [2:0]  depth;
`ifdef PC_BOUND_CHECK_EN
    logic        bound_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    program_counter_unit dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_load      (load),
        .i_call      (call),
        .i_ret       (ret),
        .i_load_addr (load_addr),
        .i_halt      (halt),
        .i_resume    (resume),
        .o_pc        (pc),
        .o_pc_next   (pc_next),
        .o_wrap      (wrap),
        .o_halted    (halted),
        .o_fault     (fault),
        .o_stack_err (stack_err),
`ifdef PC_BOUND_CHECK_EN
        .o_bound_err (bound_err),
`endif
        .o_depth     (depth)
    );

    typedef struct {
        logic [10:0] pc;
        logic        wrap;
        logic        halted;
        logic        fault;
        logic        serr;
        logic [2:0]  depth;
    } exp_t;

    typedef struct {
        logic        en, ld, cl, rt, hl, rs;
        logic [10:0] addr;
        exp_t        exp;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];

    function automatic vec_t v(input logic en, ld, cl, rt, hl, rs,
                               input logic [10:0] addr, input logic [10:0] epc,
                               input logic ew, eh, ef, es, input logic [2:0] ed);
        vec_t r;
        r.en = en; r.ld = ld; r.cl = cl; r.rt = rt; r.hl = hl; r.rs = rs;
        r.addr = addr;
        r.exp.pc = epc; r.exp.wrap = ew; r.exp.halted = eh;
        r.exp.fault = ef; r.exp.serr = es; r.exp.depth = ed;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        logic [10:0] nxt;
        nxt = e.pc + 11'd1;
        chk({tag, ".pc"},      32'(pc),        32'(e.pc));
        chk({tag, ".pc_next"}, 32'(pc_next),   32'(nxt));
        chk({tag, ".wrap"},    32'(wrap),      32'(e.wrap));
        chk({tag, ".halted"},  32'(halted),    32'(e.halted));
        chk({tag, ".fault"},   32'(fault),     32'(e.fault));
        chk({tag, ".serr"},    32'(stack_err), 32'(e.serr));
        chk({tag, ".depth"},   32'(depth),     32'(e.depth));
    endtask

    // Drive one cycle of requests, queue its expectation, compare after the edge
    task automatic apply(input vec_t t, input string tag);
        exp_t e;
        @(negedge clk);
        enable = t.en; load = t.ld; call = t.cl; ret = t.rt;
        halt = t.hl; resume = t.rs; load_addr = t.addr;
        sb.push_back(t.exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s.scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            compare(tag, e);
        end
        enable = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
        halt = 1'b0; resume = 1'b0;
    endtask

    initial begin
        exp_t rst_e;
        rst_e = '{pc: 11'h000, wrap: 1'b0, halted: 1'b0, fault: 1'b0, serr: 1'b0, depth: 3'd0};

        // Sequential advance from reset
        for (int i = 1; i <= 5; i++)
            tbl.push_back(v(1,0,0,0,0,0, 11'h000, 11'(i), 0,0,0,0, 3'd0));
        // Load near the top, advance across the wrap
        tbl.push_back(v(0,1,0,0,0,0, 11'h7FE, 11'h7FE, 0,0,0,0, 3'd0));
        tbl.push_back(v(1,0,0,0,0,0, 11'h000, 11'h7FF, 0,0,0,0, 3'd0));
        tbl.push_back(v(1,0,0,0,0,0, 11'h000, 11'h000, 1,0,0,0, 3'd0));
        tbl.push_back(v(0,0,0,0,0,0, 11'h000, 11'h000, 0,0,0,0, 3'd0));
        // Nested call / return
        tbl.push_back(v(0,1,0,0,0,0, 11'h010, 11'h010, 0,0,0,0, 3'd0));
        tbl.push_back(v(0,0,1,0,0,0, 11'h100, 11'h100, 0,0,0,0, 3'd1));
        tbl.push_back(v(0,0,1,0,0,0, 11'h200, 11'h200, 0,0,0,0, 3'd2));
        tbl.push_back(v(0,0,0,1,0,0, 11'h000, 11'h101, 0,0,0,0, 3'd1));
        tbl.push_back(v(0,0,0,1,0,0, 11'h000, 11'h011, 0,0,0,0, 3'd0));
        // Halt beats load; requests ignored in HALT; halt beats resume
        tbl.push_back(v(0,1,0,0,1,0, 11'h300, 11'h011, 0,1,0,0, 3'd0));
        tbl.push_back(v(1,0,0,0,0,0, 11'h000, 11'h011, 0,1,0,0, 3'd0));
        tbl.push_back(v(0,0,0,0,1,1, 11'h000, 11'h011, 0,1,0,0, 3'd0));
        tbl.push_back(v(0,0,0,0,0,1, 11'h000, 11'h011, 0,0,0,0, 3'd0));
        tbl.push_back(v(1,0,0,0,0,0, 11'h000, 11'h012, 0,0,0,0, 3'd0));
        // Priority: load beats call, ret beats call
        tbl.push_back(v(0,1,1,0,0,0, 11'h050, 11'h050, 0,0,0,0, 3'd0));
        tbl.push_back(v(0,0,1,0,0,0, 11'h080, 11'h080, 0,0,0,0, 3'd1));
        tbl.push_back(v(0,0,1,1,0,0, 11'h090, 11'h051, 0,0,0,0, 3'd0));
        // Fill the stack, then overflow into FAULT
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(0,0,1,0,0,0, 11'h400 + 11'(i), 11'h400 + 11'(i), 0,0,0,0, 3'(i+1)));
        tbl.push_back(v(0,0,1,0,0,0, 11'h404, 11'h403, 0,0,1,1, 3'd4));
        tbl.push_back(v(0,0,0,1,0,0, 11'h000, 11'h403, 0,0,1,0, 3'd4));
        tbl.push_back(v(0,0,0,0,1,0, 11'h000, 11'h403, 0,0,1,0, 3'd4));
        tbl.push_back(v(1,0,0,0,0,0, 11'h000, 11'h403, 0,0,1,0, 3'd4));

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 compare("reset", rst_e);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // Reset clears FAULT
        @(negedge clk);
        rst_n = 1'b0;
        #1 compare("fault_reset", rst_e);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a call sequence, away from any clock edge
        apply(v(0,0,1,0,0,0, 11'h100, 11'h100, 0,0,0,0, 3'd1), "mc1");
        apply(v(0,0,1,0,0,0, 11'h200, 11'h200, 0,0,0,0, 3'd2), "mc2");
        apply(v(0,0,1,0,0,0, 11'h300, 11'h300, 0,0,0,0, 3'd3), "mc3");
        @(negedge clk);
        call = 1'b1; load_addr = 11'h3A0;
        #2 rst_n = 1'b0;
        #1 compare("midcall_reset", rst_e);
        call = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Return on empty stack
        apply(v(0,0,0,1,0,0, 11'h000, 11'h000, 0,0,1,1, 3'd0), "ret_empty");
        apply(v(1,0,0,0,0,0, 11'h000, 11'h000, 0,0,1,0, 3'd0), "ret_empty_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_program_counter_unit

`default_nettype wire
